// File: rtl/tag_nios_system_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tag_nios_system_pll_reset_sequencer
//
// Brings a PLL out of reset, waits for it to lock, waits for the lock to be
// stable, and only then releases the system reset. A lock that never arrives
// is retried a bounded number of times before the block parks in FAULT until
// software pulses clear_fault. A lock loss while running drops the system
// reset and restarts the whole sequence.
//
// Parameters
//   LOCK_TIMEOUT    cycles to wait for lock before retrying the PLL reset
//   STABLE_CYCLES   consecutive locked cycles required before RUN
//   PLL_RST_CYCLES  width of the PLL reset pulse in cycles
//   MAX_RETRIES     failed lock attempts before FAULT (legal 1..15)
//
// Ports
//   clk             PLL reference clock, the only clock
//   reset_n         asynchronous active-low reset, released synchronously
//   pll_locked      PLL lock indication, asynchronous to clk
//   clear_fault     single-cycle pulse, leaves FAULT (ignored elsewhere)
//   pll_rst         active-high reset to the PLL (PLL_RESET and FAULT only)
//   sys_reset_n     registered active-low system reset (high only in RUN)
//   fault           lock retries exhausted
//   retry_count     failed lock attempts since the last successful lock
//   lock_loss_count saturating count of lock losses observed in RUN
// ---------------------------------------------------------------------------
module tag_nios_system_pll_reset_sequencer #(
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int PLL_RST_CYCLES = 16,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       clear_fault,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  // One counter is shared by every timed state, so it only has to span the
  // longest interval. It counts 0..N-1, hence clog2(N) bits are enough.
  localparam int CNT_MAX = (LOCK_TIMEOUT > STABLE_CYCLES) ?
                           ((LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES) :
                           ((STABLE_CYCLES > PLL_RST_CYCLES) ? STABLE_CYCLES : PLL_RST_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sync_pipe;
  logic          locked_s;
  logic [3:0]    retry_next;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous lock flag. Nothing below ever
  // looks at pll_locked directly.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_pipe <= 2'b00;
    else          sync_pipe <= {sync_pipe[0], pll_locked};
  end

  assign locked_s   = sync_pipe[1];
  assign retry_next = retry_count + 4'd1;

  // -------------------------------------------------------------------------
  // Sequencer. All outputs are registered and updated on the same edge as the
  // state transition that changes them, so sys_reset_n rises on the edge that
  // enters RUN and falls on the edge that leaves it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= PLL_RESET;
      cnt             <= '0;
      pll_rst         <= 1'b1;
      sys_reset_n     <= 1'b0;
      fault           <= 1'b0;
      retry_count     <= 4'd0;
      lock_loss_count <= 8'd0;
    end else begin
      case (state)
        // Hold the PLL in reset for exactly PLL_RST_CYCLES cycles; the lock
        // flag is meaningless while the PLL is being reset.
        PLL_RESET: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Lock is tested before the timeout so a lock that shows up on the
        // very last cycle of the window is accepted rather than retried.
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABILIZE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_count <= retry_next;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            if (retry_next == RETRY_LIMIT) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state <= PLL_RESET;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Any drop restarts the stability window from WAIT_LOCK. This is not
        // a failed attempt, so retry_count is left alone.
        STABILIZE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state       <= RUN;
            cnt         <= '0;
            sys_reset_n <= 1'b1;
            retry_count <= 4'd0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Lock loss in service: drop the system reset on the next edge and
        // go through a full PLL reset again.
        RUN: begin
          if (!locked_s) begin
            state       <= PLL_RESET;
            cnt         <= '0;
            sys_reset_n <= 1'b0;
            pll_rst     <= 1'b1;
            if (lock_loss_count != 8'hFF)
              lock_loss_count <= lock_loss_count + 8'd1;
          end
        end

        // Parked with the PLL held in reset until software intervenes.
        // pll_rst is already high and stays high into PLL_RESET.
        FAULT: begin
          if (clear_fault) begin
            state       <= PLL_RESET;
            cnt         <= '0;
            fault       <= 1'b0;
            retry_count <= 4'd0;
          end
        end

        default: begin
          state       <= PLL_RESET;
          cnt         <= '0;
          pll_rst     <= 1'b1;
          sys_reset_n <= 1'b0;
          fault       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tag_nios_system_pll_reset_sequencer.md
TAG_NIOS_SYSTEM_PLL_RESET_SEQUENCER -- requirements
Module: tag_nios_system_pll_reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 50000, meaning the number of cycles to wait for lock before retrying.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024, meaning the consecutive cycles of lock required before system reset release.
REQ-003 SHALL have parameter PLL_RST_CYCLES, default 16, meaning the PLL reset pulse width in cycles.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, meaning the number of failed lock attempts before fault; legal range 1..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock (PLL reference clock domain).
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL locked indication, asynchronous to clk.
REQ-008 SHALL have port clear_fault, input, 1 bit: single-cycle pulse that exits FAULT.
REQ-009 SHALL have port pll_rst, output, 1 bit: active-high reset to PLL.
REQ-010 SHALL have port sys_reset_n, output, 1 bit: active-low system reset, registered.
REQ-011 SHALL have port fault, output, 1 bit: lock retries exhausted.
REQ-012 SHALL have port retry_count, output, 4 bits: failed attempts since last successful lock.
REQ-013 SHALL have port lock_loss_count, output, 8 bits: saturating count of lock losses while in RUN.

Function
REQ-014 SHALL synchronize pll_locked through a 2-flop synchronizer (locked_s); all decisions SHALL use only locked_s.
REQ-015 SHALL implement states PLL_RESET, WAIT_LOCK, STABILIZE, RUN, FAULT with one shared cycle counter, cleared on every state change.
REQ-016 PLL_RESET: pll_rst=1, sys_reset_n=0; after PLL_RST_CYCLES cycles SHALL go to WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0, sys_reset_n=0; locked_s=1 SHALL go to STABILIZE.
REQ-018 WAIT_LOCK timeout: if the counter reaches LOCK_TIMEOUT-1 with locked_s=0, retry_count SHALL increment; if the new value equals MAX_RETRIES, SHALL go to FAULT, else to PLL_RESET.
REQ-019 WAIT_LOCK: lock arriving in the same cycle as timeout SHALL win (go to STABILIZE, no increment).
REQ-020 STABILIZE: locked_s=0 SHALL return to WAIT_LOCK with no retry increment; after STABLE_CYCLES consecutive cycles with locked_s=1, SHALL go to RUN.
REQ-021 Entering RUN SHALL set sys_reset_n=1 on the same edge and clear retry_count.
REQ-022 RUN: locked_s=0 SHALL force sys_reset_n=0 on the next edge, increment lock_loss_count (saturate at 255), and go to PLL_RESET.
REQ-023 FAULT: pll_rst=1, sys_reset_n=0, fault=1; clear_fault=1 SHALL go to PLL_RESET and clear fault and retry_count; clear_fault SHALL be ignored in all other states.
REQ-024 Latency: with the pll_locked rise first sampled at edge 1 in WAIT_LOCK and held high, sys_reset_n SHALL rise at edge STABLE_CYCLES+3.
REQ-025 sys_reset_n SHALL never be 1 outside RUN; pll_rst SHALL be 1 only in PLL_RESET and FAULT.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state PLL_RESET, counter=0, synchronizer flops=0, pll_rst=1, sys_reset_n=0, fault=0, retry_count=0, lock_loss_count=0.
REQ-027 Reset deassertion SHALL be taken synchronously; the first PLL_RESET period SHALL last PLL_RST_CYCLES cycles after release.
REQ-028 Assertion of reset_n mid-operation, in any state, SHALL produce the REQ-026 values immediately, without waiting for a clock edge.

Verification (LOCK_TIMEOUT=20, STABLE_CYCLES=8, PLL_RST_CYCLES=4, MAX_RETRIES=2)
REQ-029 Release reset, pll_locked=1 from cycle 6 -> pll_rst high for 4 cycles, sys_reset_n rises at edge 11 after the lock is first sampled, retry_count=0.
REQ-030 pll_locked held 0 -> two 20-cycle WAIT_LOCK windows, retry_count 1 then 2, fault=1, pll_rst=1; clear_fault pulse -> fault=0, retry_count=0, new 4-cycle pll_rst pulse.
REQ-031 Lock glitch low for 1 cycle at STABILIZE count 5 -> return to WAIT_LOCK, retry_count unchanged; stable relock -> RUN 11 edges after the relock is first sampled.
REQ-032 In RUN, drop pll_locked -> sys_reset_n=0 three edges after the drop, lock_loss_count=1, pll_rst pulse; repeat 300 times -> lock_loss_count=255.
REQ-033 Assert reset_n mid-STABILIZE and mid-RUN -> all outputs take REQ-026 values without a clock edge; lock_loss_count returns to 0.
